// File: rtl/fib_fill_ctrl.sv
// fib_fill_ctrl: fills register-file entries 2..end_addr with the recurrence
// data[i] = data[i-2] + data[i-1]. It uses the register file's two
// combinational read ports to fetch the operands and its single write port
// to store the sum.
//
// Each entry takes two cycles. RD presents both operand addresses and
// registers their sum. WR writes that sum back.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   start           request a run (sampled only in IDLE)
//   abort           cancel a running fill (RD/WR only)
//   end_addr        last address to write, latched when start is accepted
//   rAddrA/rAddrB   read addresses for operands i-2 / i-1
//   rDinA/rDinB     combinational read data for rAddrA / rAddrB
//   wAddr/wDin/wEna register-file write port
//   busy            high in RD and WR
//   done            one-cycle completion pulse
//   ovf             sticky carry-out flag, cleared by an accepted start
module fib_fill_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rAddrA,
  output logic [ADDR_W-1:0] rAddrB,
  input  logic [DATA_W-1:0] rDinA,
  input  logic [DATA_W-1:0] rDinB,
  output logic [ADDR_W-1:0] wAddr,
  output logic [DATA_W-1:0] wDin,
  output logic              wEna,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W:0]     sum_full;

  // Unsigned add that keeps the carry out in the top bit.
  function automatic logic [DATA_W:0] add_wc(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= ADDR_W'(2);
      end_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    end_d    = end_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    sum_full = add_wc(rDinA, rDinB);
    rAddrA   = '0;
    rAddrB   = ADDR_W'(1);
    wAddr    = '0;
    wDin     = '0;
    wEna     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // start has priority over abort here; abort has no meaning in IDLE.
        if (start) begin
          ovf_d = 1'b0;
          if (end_addr >= ADDR_W'(2)) begin
            end_d   = end_addr;
            ptr_d   = ADDR_W'(2);
            state_d = RD;
          end else begin
            state_d = DONE;
          end
        end
      end
      // Operand fetch: sum the two preceding entries.
      RD: begin
        busy   = 1'b1;
        rAddrA = ptr_q - ADDR_W'(2);
        rAddrB = ptr_q - ADDR_W'(1);
        if (abort) begin
          state_d = IDLE;
        end else begin
          sum_d = sum_full[DATA_W-1:0];
          if (sum_full[DATA_W]) ovf_d = 1'b1;
          state_d = WR;
        end
      end
      // Write-back: store the registered sum at ptr.
      WR: begin
        busy  = 1'b1;
        wAddr = ptr_q;
        wDin  = sum_q;
        if (abort) begin
          state_d = IDLE;
        end else begin
          wEna = 1'b1;
          // end_q <= 63 means ptr stops before it can wrap.
          if (ptr_q == end_q) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = RD;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_fib_fill_ctrl.sv
// Directed testbench for fib_fill_ctrl. A small 64x32 register-file model
// with combinational reads sits next to the DUT. Reset preloads entries 0
// and 1 with 2. clr_req zeroes entries 2..63. wr_cnt counts write strobes.
module tb_fib_fill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [5:0]  end_addr;
  logic [5:0]  rAddrA, rAddrB, wAddr;
  logic [31:0] rDinA, rDinB, wDin;
  logic        wEna, busy, done, ovf;

  logic [31:0] mem [64];
  logic        clr_req;
  int          wr_cnt;

  int n_vec;
  int n_err;

  fib_fill_ctrl #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .end_addr (end_addr),
    .rAddrA   (rAddrA),
    .rAddrB   (rAddrB),
    .rDinA    (rDinA),
    .rDinB    (rDinB),
    .wAddr    (wAddr),
    .wDin     (wDin),
    .wEna     (wEna),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rDinA = mem[rAddrA];
  assign rDinB = mem[rAddrB];

  always @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= 32'd2;
      mem[1] <= 32'd2;
    end
    if (clr_req) begin
      for (int i = 2; i < 64; i++) mem[i] <= 32'd0;
    end else if (wEna) begin
      mem[wAddr] <= wDin;
      wr_cnt     <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [5:0] e);
    end_addr = e;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic clear_mem();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
  endtask

  // Leaves the bench in the DONE cycle, or reports a timeout.
  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      step();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  logic [31:0] wr_exp [4];
  int          wc;

  initial begin
    wr_exp[0] = 32'd4; wr_exp[1] = 32'd6; wr_exp[2] = 32'd10; wr_exp[3] = 32'd16;
    n_vec = 0; n_err = 0; wr_cnt = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; end_addr = '0; clr_req = 1'b1;
    #3;
    chk("rst_wEna",   32'(wEna),   32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_rAddrA", 32'(rAddrA), 32'd0);
    chk("rst_rAddrB", 32'(rAddrB), 32'd1);
    chk("rst_ovf",    32'(ovf),    32'd0);
    #9;                       // past the edge at 5: preload + clear done
    rst_n = 1'b1; clr_req = 1'b0;
    step();

    // end_addr=5: writes 4,6,10,16 on cycles 2,4,6,8; done on cycle 9
    do_start(6'd5);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("r5_busy_c%0d", k), 32'(busy), 32'd1);
      if (k % 2 == 0) begin
        chk($sformatf("r5_wEna_c%0d", k),  32'(wEna),  32'd1);
        chk($sformatf("r5_wAddr_c%0d", k), 32'(wAddr), 32'(k / 2 + 1));
        chk($sformatf("r5_wDin_c%0d", k),  wDin,       wr_exp[k / 2 - 1]);
      end else begin
        chk($sformatf("r5_wEna_c%0d", k),   32'(wEna),   32'd0);
        chk($sformatf("r5_rAddrA_c%0d", k), 32'(rAddrA), 32'((k - 1) / 2));
        chk($sformatf("r5_rAddrB_c%0d", k), 32'(rAddrB), 32'((k + 1) / 2));
      end
      step();
    end
    chk("r5_done_c9", 32'(done), 32'd1);
    chk("r5_busy_c9", 32'(busy), 32'd0);
    chk("r5_ovf",     32'(ovf),  32'd0);
    step();
    chk("r5_done_c10", 32'(done), 32'd0);
    chk("r5_mem5",     mem[5],    32'd16);

    // end_addr=45: data[45] = 2*F(46)
    do_start(6'd45);
    wait_done(200);
    step();
    chk("r45_mem45", mem[45], 32'hDAE7CABE);
    chk("r45_ovf",   32'(ovf), 32'd0);

    // end_addr=46 wraps; next accepted start clears ovf
    do_start(6'd46);
    wait_done(200);
    chk("r46_ovf", 32'(ovf), 32'd1);
    step();
    chk("r46_mem46", mem[46], 32'h623249C2);
    do_start(6'd3);
    chk("r3_ovf_cleared", 32'(ovf), 32'd0);
    wait_done(20);
    step();

    // end_addr=1 and 0: straight to DONE, no writes
    for (int e = 0; e < 2; e++) begin
      wc = wr_cnt;
      do_start(6'(e));
      chk($sformatf("short%0d_done", e), 32'(done), 32'd1);
      chk($sformatf("short%0d_busy", e), 32'(busy), 32'd0);
      chk($sformatf("short%0d_wEna", e), 32'(wEna), 32'd0);
      step();
      chk($sformatf("short%0d_done_off", e), 32'(done), 32'd0);
      chk($sformatf("short%0d_nowrite", e), 32'(wr_cnt), 32'(wc));
    end

    // abort during the WR cycle for address 4 (cycle 6)
    clear_mem();
    do_start(6'd10);
    for (int k = 1; k < 6; k++) step();
    abort = 1'b1;
    #1;
    chk("abort_wEna", 32'(wEna), 32'd0);
    chk("abort_wAddr", 32'(wAddr), 32'd4);
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_mem2", mem[2], 32'd4);
    chk("abort_mem3", mem[3], 32'd6);
    chk("abort_mem4", mem[4], 32'd0);
    step();
    chk("abort_done_late", 32'(done), 32'd0);
    do_start(6'd5);
    wait_done(20);
    step();
    chk("post_abort_mem4", mem[4], 32'd10);
    chk("post_abort_mem5", mem[5], 32'd16);

    // rst_n low during a WR cycle
    clear_mem();
    do_start(6'd10);
    step();                   // cycle 2: WR for address 2
    chk("mr_wEna_pre", 32'(wEna), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_wEna_async", 32'(wEna), 32'd0);
    chk("mr_busy_async", 32'(busy), 32'd0);
    step();
    chk("mr_mem2", mem[2], 32'd0);
    #3;
    rst_n = 1'b1;
    step();
    chk("mr_idle_busy",   32'(busy),   32'd0);
    chk("mr_idle_rAddrB", 32'(rAddrB), 32'd1);

    // start during busy is ignored; end_addr change has no effect
    wc = wr_cnt;
    do_start(6'd3);
    end_addr = 6'd10;
    start    = 1'b1;
    step();
    start    = 1'b0;
    wait_done(20);
    step();
    for (int k = 0; k < 10; k++) begin
      if (busy || wEna) chk("second_run", 32'({busy, wEna}), 32'd0);
      step();
    end
    chk("ignored_start_writes", 32'(wr_cnt - wc), 32'd2);
    chk("ignored_start_mem3",   mem[3], 32'd6);
    chk("ignored_start_mem4",   mem[4], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
